// File: rtl/morse_pkg.sv
// Shared symbol codes and SOS pattern for the Morse classifier.
// Optional SOS matcher is built only with MORSE_SOS_EN.
package morse_pkg;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_DOT   = 2'b00;
  localparam sym_t SYM_SPACE = 2'b10;
  localparam sym_t SYM_DASH  = 2'b11;

  // History bit per mark: 1 = dash. Symmetric, so shift order is moot.
  localparam int SOS_LEN = 9;
  localparam logic [SOS_LEN-1:0] SOS_PAT = 9'b000_111_000;

  function automatic logic is_mark(sym_t s);
    return (s == SYM_DOT) || (s == SYM_DASH);
  endfunction

endpackage

// File: rtl/morse_sos_match.sv
// Nine-deep dot/dash history that strobes sos_found on ...---...
// Built only when MORSE_SOS_EN is defined.
module morse_sos_match
  import morse_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic [1:0] sym,
  output logic       sos_found
);

  logic [SOS_LEN-1:0] hist;
  logic [SOS_LEN-1:0] hist_nxt;
  logic [3:0]         fill;
  logic [3:0]         fill_nxt;
  logic               hit;
  logic               take;

  assign take = sym_valid && is_mark(sym);

  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    hit      = 1'b0;
    if (take) begin
      hist_nxt = {hist[SOS_LEN-2:0], sym == SYM_DASH};
      if (fill != 4'(SOS_LEN)) begin
        fill_nxt = fill + 4'd1;
      end
      // fill guards against the cleared zeros posing as dots
      hit = (fill >= 4'(SOS_LEN - 1)) &&
            (hist_nxt == SOS_PAT);
      if (hit) begin
        hist_nxt = '0;
        fill_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist      <= '0;
      fill      <= '0;
      sos_found <= 1'b0;
    end else begin
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      sos_found <= hit;
    end
  end

endmodule

// File: rtl/morse_dash_dot.sv
// Serial Morse run-length classifier: dot, dash and space strobes.
// Define MORSE_SOS_EN to add the sos_found output and matcher.
module morse_dash_dot
  import morse_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int DOT_MAX   = 2,
  parameter int SPACE_MIN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  output logic       ready,
  output logic [1:0] symbol
`ifdef MORSE_SOS_EN
  ,
  output logic       sos_found
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_LIM = CNT_W'(DOT_MAX);
  localparam logic [CNT_W:0]   SPC_AT  = (CNT_W+1)'(SPACE_MIN);

  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] hi_nxt;
  logic [CNT_W-1:0] lo_cnt;
  logic [CNT_W-1:0] lo_nxt;
  logic [CNT_W:0]   lo_inc;
  logic             armed;
  logic             armed_nxt;
  logic             ready_nxt;
  sym_t             sym_nxt;

  logic in_mark;
  logic mark_end;
  logic in_gap;

  assign in_mark  = data_in;
  assign mark_end = !data_in && (hi_cnt != '0);
  assign in_gap   = !data_in && (hi_cnt == '0);

  // Unsaturated so a pinned counter can never re-hit SPACE_MIN
  assign lo_inc = {1'b0, lo_cnt} + (CNT_W+1)'(1);

  always_comb begin
    hi_nxt    = hi_cnt;
    lo_nxt    = lo_cnt;
    armed_nxt = armed;
    ready_nxt = 1'b0;
    sym_nxt   = symbol;
    unique case (1'b1)
      in_mark: begin
        if (hi_cnt != CNT_MAX) begin
          hi_nxt = hi_cnt + CNT_ONE;
        end
        lo_nxt    = '0;
        armed_nxt = 1'b1;
      end
      mark_end: begin
        ready_nxt = 1'b1;
        sym_nxt   = (hi_cnt <= DOT_LIM) ?
                    SYM_DOT : SYM_DASH;
        hi_nxt    = '0;
        lo_nxt    = CNT_ONE;
      end
      in_gap: begin
        if (lo_cnt != CNT_MAX) begin
          lo_nxt = lo_cnt + CNT_ONE;
        end
        if (armed && (lo_inc == SPC_AT)) begin
          ready_nxt = 1'b1;
          sym_nxt   = SYM_SPACE;
          armed_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
      armed  <= 1'b0;
      ready  <= 1'b0;
      symbol <= SYM_DOT;
    end else begin
      hi_cnt <= hi_nxt;
      lo_cnt <= lo_nxt;
      armed  <= armed_nxt;
      ready  <= ready_nxt;
      symbol <= sym_nxt;
    end
  end

`ifdef MORSE_SOS_EN
  morse_sos_match u_sos (
    .clk       (clk),
    .rst_n     (rst_n),
    .sym_valid (ready),
    .sym       (symbol),
    .sos_found (sos_found)
  );
`endif

endmodule

// File: tb/tb_morse_dash_dot.sv
// Bench for morse_dash_dot: directed and random runs vs run-length model.
// Checks sos_found too when built with MORSE_SOS_EN.
module tb_morse_dash_dot;

  localparam int DOT_MAX   = 2;
  localparam int SPACE_MIN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_in;
  logic       ready;
  logic [1:0] symbol;
`ifdef MORSE_SOS_EN
  logic       sos_found;
`endif

  int total = 0;
  int bad   = 0;

  // run-level model state
  int         mlen;
  int         glen;
  bit         seen;
  logic       exp_ready;
  logic [1:0] exp_sym;
`ifdef MORSE_SOS_EN
  bit         marks[$];
  bit         pend;
  logic       exp_sos;
  int         sos_seen;
`endif

  morse_dash_dot #(
    .CNT_W     (4),
    .DOT_MAX   (DOT_MAX),
    .SPACE_MIN (SPACE_MIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .ready     (ready),
    .symbol    (symbol)
`ifdef MORSE_SOS_EN
    ,
    .sos_found (sos_found)
`endif
  );

  always #5 clk = ~clk;

`ifdef MORSE_SOS_EN
  function automatic bit tail_is_sos();
    bit pat [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    int n = marks.size();
    if (n < 9) return 1'b0;
    for (int i = 0; i < 9; i++)
      if (marks[n - 9 + i] != pat[i]) return 1'b0;
    return 1'b1;
  endfunction
`endif

  task automatic model(input logic d, input logic r);
`ifdef MORSE_SOS_EN
    exp_sos = r ? pend : 1'b0;
    pend = 1'b0;
`endif
    if (!r) begin
      mlen = 0; glen = 0; seen = 1'b0;
      exp_ready = 1'b0; exp_sym = 2'b00;
`ifdef MORSE_SOS_EN
      marks.delete();
`endif
    end else if (d) begin
      mlen++; glen = 0; seen = 1'b1;
      exp_ready = 1'b0;
    end else if (mlen > 0) begin
      exp_ready = 1'b1;
      exp_sym = (mlen <= DOT_MAX) ? 2'b00 : 2'b11;
`ifdef MORSE_SOS_EN
      marks.push_back(mlen > DOT_MAX);
      if (tail_is_sos()) begin
        pend = 1'b1;
        marks.delete();
      end
`endif
      mlen = 0; glen = 1;
    end else begin
      glen++;
      exp_ready = 1'b0;
      if (glen == SPACE_MIN && seen) begin
        exp_ready = 1'b1;
        exp_sym = 2'b10;
        seen = 1'b0;
      end
    end
  endtask

  task automatic step(input logic d, input logic r, input string tag);
    data_in = d;
    rst_n = r;
    @(posedge clk);
    #1;
    model(d, r);
    total++;
    assert (ready === exp_ready) else begin
      bad++;
      $error("FAIL %s.ready t=%0t got=%b want=%b",
             tag, $time, ready, exp_ready);
    end
    total++;
    assert (symbol === exp_sym) else begin
      bad++;
      $error("FAIL %s.symbol t=%0t got=%b want=%b",
             tag, $time, symbol, exp_sym);
    end
`ifdef MORSE_SOS_EN
    total++;
    if (sos_found === 1'b1) sos_seen++;
    assert (sos_found === exp_sos) else begin
      bad++;
      $error("FAIL %s.sos t=%0t got=%b want=%b",
             tag, $time, sos_found, exp_sos);
    end
`endif
  endtask

  task automatic mark(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, tag);
  endtask

  task automatic low(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, tag);
  endtask

`ifdef MORSE_SOS_EN
  task automatic letter(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      mark((s[i] == "-") ? 3 : 1, tag);
      low(1, tag);
    end
    low(5, tag);
  endtask
`endif

  initial begin
    int ml;
    int gl;
    mlen = 0; glen = 0; seen = 1'b0;
    exp_ready = 1'b0; exp_sym = 2'b00;
`ifdef MORSE_SOS_EN
    pend = 1'b0; exp_sos = 1'b0; sos_seen = 0;
`endif
    data_in = 1'b0;
    rst_n = 1'b0;

    // reset with toggling line
    step(1'b1, 1'b0, "rst");
    step(1'b0, 1'b0, "rst");
    step(1'b1, 1'b0, "rst");

    // idle low straight out of reset: no space
    low(8, "idle");

    // dots of 1 and 2 cycles
    mark(1, "dot1"); low(2, "dot1");
    mark(2, "dot2"); low(2, "dot2");

    // dashes of 3 and 20 cycles
    mark(3, "dash3"); low(2, "dash3");
    mark(20, "dash20"); low(2, "dash20");

    // mark then a long gap: exactly one space
    mark(1, "space"); low(10, "space");
    mark(4, "space2"); low(10, "space2");

    // back-to-back marks with single low cycles
    mark(1, "b2b"); low(1, "b2b");
    mark(3, "b2b"); low(1, "b2b");
    mark(2, "b2b"); low(6, "b2b");

    // reset mid-gap discards space arming
    mark(1, "midgap"); low(2, "midgap");
    step(1'b0, 1'b0, "midgap");
    low(6, "midgap");

    // reset mid-mark discards the mark
    mark(3, "midmark");
    step(1'b1, 1'b0, "midmark");
    low(6, "midmark");

`ifdef MORSE_SOS_EN
    letter("...", "sos");
    letter("---", "sos");
    letter("...", "sos");
    low(2, "sos");
    total++;
    assert (sos_seen == 1) else begin
      bad++;
      $error("FAIL sos_count got=%0d want=1", sos_seen);
    end
    letter("..", "nosos");
    letter("---", "nosos");
    letter("...", "nosos");
    low(2, "nosos");
    total++;
    assert (sos_seen == 1) else begin
      bad++;
      $error("FAIL nosos_count got=%0d want=1", sos_seen);
    end
`endif

    // random runs
    for (int k = 0; k < 150; k++) begin
      ml = ($urandom_range(0, 7) == 0) ?
           int'($urandom_range(15, 25)) :
           int'($urandom_range(1, 5));
      gl = int'($urandom_range(1, 8));
      mark(ml, "rnd");
      if ($urandom_range(0, 14) == 0)
        step($urandom_range(0, 1) == 1, 1'b0, "rnd_rst");
      low(gl, "rnd");
    end
    low(6, "tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
